// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types, lamp constants and phase helpers for the traffic phase controller.
// The TLC_PED_EN macro adds pedestrian service in the controller and its interface.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic int unsigned phase_dur(state_t s, int unsigned green_s,
                                            int unsigned yellow_s, int unsigned allred_s);
    case (s)
      NS_GREEN, EW_GREEN:   return green_s;
      NS_YELLOW, EW_YELLOW: return yellow_s;
      default:              return allred_s;
    endcase
  endfunction

  function automatic state_t next_phase(state_t s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED_A;
      ALLRED_A:  return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALLRED_B;
      default:   return NS_GREEN;
    endcase
  endfunction

  function automatic logic is_legal(state_t s);
    return 3'(s) <= 3'(ALLRED_B);
  endfunction

  function automatic logic is_green(state_t s);
    return (s == NS_GREEN) || (s == EW_GREEN);
  endfunction

  function automatic logic is_allred(state_t s);
    return (s == ALLRED_A) || (s == ALLRED_B);
  endfunction

  function automatic logic dur_ok(int unsigned d, int unsigned w);
    return (d >= 1) && (64'(d) <= ((64'd1 << w) - 64'd1));
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Tick input and lamp/countdown outputs of the traffic phase controller.
// With TLC_PED_EN defined, ped_req and walk are carried as well.
interface traffic_phase_ctrl_if #(parameter int unsigned CNT_W = 8);
  logic             tick;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic [CNT_W-1:0] countdown;
  logic [2:0]       phase;
`ifdef TLC_PED_EN
  logic             ped_req;
  logic             walk;

  modport master (output tick, output ped_req,
                  input ns_light, input ew_light, input countdown, input phase, input walk);
  modport slave  (input tick, input ped_req,
                  output ns_light, output ew_light, output countdown, output phase, output walk);
`else
  modport master (output tick,
                  input ns_light, input ew_light, input countdown, input phase);
  modport slave  (input tick,
                  output ns_light, output ew_light, output countdown, output phase);
`endif
endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Loadable down-counter timing the current phase; expire flags the tick that ends it.
module phase_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= CNT_W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (tick)
      count <= count - CNT_W'(1);
  end

  assign expire = tick && (count == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer driven by a 1 Hz tick enable.
// Optional pedestrian walk service is built when TLC_PED_EN is defined.
module traffic_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_S  = 10,
  parameter int unsigned YELLOW_S = 3,
  parameter int unsigned ALLRED_S = 1,
  parameter int unsigned CNT_W    = 8
`ifdef TLC_PED_EN
  ,
  parameter int unsigned PED_CUT_S = 3,
  parameter int unsigned WALK_S    = 5
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

`ifdef TLC_PED_EN
  localparam logic DUR_BAD = !dur_ok(PED_CUT_S, CNT_W) || !dur_ok(WALK_S, CNT_W);
`else
  localparam logic DUR_BAD = 1'b0;
`endif

  if (!dur_ok(GREEN_S, CNT_W) || !dur_ok(YELLOW_S, CNT_W) ||
      !dur_ok(ALLRED_S, CNT_W) || DUR_BAD) begin : g_bad_duration
    $error("traffic_phase_ctrl: every duration must be in 1..2^CNT_W-1");
  end

  state_t           state_q, state_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             expire;
  logic [2:0]       ns_q, ew_q, ns_d, ew_d;
`ifdef TLC_PED_EN
  logic             ped_pend, serve, walk_q, walk_d;
`endif

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_S)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (bus.tick),
    .count    (count),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ALLRED_B;
      ns_q     <= LAMP_R;
      ew_q     <= LAMP_R;
`ifdef TLC_PED_EN
      ped_pend <= 1'b0;
      walk_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
`ifdef TLC_PED_EN
      // A request on the serving edge itself stays pending for the next cycle.
      ped_pend <= (ped_pend & ~serve) | bus.ped_req;
      walk_q   <= walk_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = CNT_W'(ALLRED_S);
`ifdef TLC_PED_EN
    serve    = 1'b0;
`endif
    if (!is_legal(state_q)) begin
      state_d = ALLRED_B;
      load    = 1'b1;
    end else if (expire) begin
      state_d  = next_phase(state_q);
      load     = 1'b1;
      load_val = CNT_W'(phase_dur(state_d, GREEN_S, YELLOW_S, ALLRED_S));
`ifdef TLC_PED_EN
      if (is_allred(state_d) && ped_pend) begin
        serve    = 1'b1;
        load_val = CNT_W'(WALK_S);
      end
`endif
    end
`ifdef TLC_PED_EN
    else if (bus.tick && is_green(state_q) && ped_pend && (count > CNT_W'(PED_CUT_S))) begin
      load     = 1'b1;
      load_val = CNT_W'(PED_CUT_S);
    end
`endif
  end

  always_comb begin
    ns_d = LAMP_R;
    ew_d = LAMP_R;
    case (state_d)
      NS_GREEN:  ns_d = LAMP_G;
      NS_YELLOW: ns_d = LAMP_Y;
      EW_GREEN:  ew_d = LAMP_G;
      EW_YELLOW: ew_d = LAMP_Y;
      default:   ;
    endcase
`ifdef TLC_PED_EN
    if (serve)
      walk_d = 1'b1;
    else if (state_d != state_q)
      walk_d = 1'b0;
    else
      walk_d = walk_q;
`endif
  end

  assign bus.ns_light  = ns_q;
  assign bus.ew_light  = ew_q;
  assign bus.countdown = count;
  assign bus.phase     = 3'(state_q);
`ifdef TLC_PED_EN
  assign bus.walk      = walk_q;
`endif

endmodule
